// File: rtl/wb_sequencer.sv
// wb_sequencer: multicycle write-back controller for the register file.
// Decodes a started instruction into a write class and walks it through
// zero, one or two register-file writes. POP is the only two-write class:
// rt from memory, then $sp+4. Outputs are Moore, decoded from the state
// register and the latched class.
module wb_sequencer #(
  parameter logic [5:0] OP_PUSH     = 6'h3E,
  parameter logic [5:0] OP_POP      = 6'h3F,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         TCNT_W      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       flush,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       busy,
  output logic       reg_write,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] wb_src_sel,
  output logic       sp_inc,
  output logic       done,
  output logic       mem_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_MEM_WAIT, S_WB_MEM, S_WB_SP, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_IALU, C_LOAD, C_JAL, C_PUSH, C_POP
  } cls_t;

  // mux_WR_Registers destination encoding
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_SP = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;
  localparam logic [1:0] DST_RD = 2'b11;
  // write-data source encoding
  localparam logic [1:0] SRC_ALU    = 2'b00;
  localparam logic [1:0] SRC_MEM    = 2'b01;
  localparam logic [1:0] SRC_PC     = 2'b10;
  localparam logic [1:0] SRC_SP_ADJ = 2'b11;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  cls_t              cls, dec_cls;
  logic [TCNT_W-1:0] tcnt;
  logic              err_flag;
  logic              tcnt_hit;

  assign tcnt_hit = (tcnt == TCNT_LAST);

  // Instruction class decode from the raw opcode/funct inputs.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves it unassigned would otherwise infer a latch.
    dec_cls = C_NONE;
    if (opcode == OP_PUSH)                        dec_cls = C_PUSH;
    else if (opcode == OP_POP)                    dec_cls = C_POP;
    else if (opcode == 6'h00 && funct != 6'h08)   dec_cls = C_RTYPE;
    else if (opcode inside {6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F})
                                                  dec_cls = C_IALU;
    else if (opcode inside {6'h20, 6'h21, 6'h23}) dec_cls = C_LOAD;
    else if (opcode == 6'h03)                     dec_cls = C_JAL;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides everything, including start in IDLE.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          unique case (dec_cls)
            C_RTYPE, C_IALU, C_JAL, C_PUSH: state_nxt = S_WB;
            C_LOAD, C_POP:                  state_nxt = S_MEM_WAIT;
            default:                        state_nxt = S_DONE;
          endcase
        end
        S_WB:       state_nxt = S_DONE;
        S_MEM_WAIT: if (mem_ready)     state_nxt = S_WB_MEM;
                    else if (tcnt_hit) state_nxt = S_DONE;
        S_WB_MEM:   state_nxt = (cls == C_POP) ? S_WB_SP : S_DONE;
        S_WB_SP:    state_nxt = S_DONE;
        S_DONE:     state_nxt = S_IDLE;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // Class latch, memory-wait counter and timeout flag. Both counter and flag
  // are held clear while idle, so each MEM_WAIT entry starts fresh and a
  // class that never waits cannot report a stale timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls      <= C_NONE;
      tcnt     <= '0;
      err_flag <= 1'b0;
    end else if (state == S_IDLE) begin
      tcnt     <= '0;
      err_flag <= 1'b0;
      if (start && !flush) cls <= dec_cls;
    end else if (state == S_MEM_WAIT) begin
      tcnt <= tcnt + 1'b1;
      if (!mem_ready && tcnt_hit && !flush) err_flag <= 1'b1;
    end
  end

  // Moore outputs from state and latched class; selects are 0 outside writes.
  always_comb begin
    busy            = (state != S_IDLE);
    reg_write       = 1'b0;
    reg_dst_sel     = DST_RT;
    wb_src_sel      = SRC_ALU;
    sp_inc          = 1'b0;
    done            = 1'b0;
    mem_timeout_err = 1'b0;
    unique case (state)
      S_WB: begin
        reg_write = 1'b1;
        unique case (cls)
          C_RTYPE: reg_dst_sel = DST_RD;
          C_JAL: begin
            reg_dst_sel = DST_RA;
            wb_src_sel  = SRC_PC;
          end
          C_PUSH: begin
            reg_dst_sel = DST_SP;
            wb_src_sel  = SRC_SP_ADJ;
          end
          default: reg_dst_sel = DST_RT;
        endcase
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wb_src_sel = SRC_MEM;
      end
      S_WB_SP: begin
        reg_write   = 1'b1;
        reg_dst_sel = DST_SP;
        wb_src_sel  = SRC_SP_ADJ;
        sp_inc      = 1'b1;
      end
      S_DONE: begin
        done            = 1'b1;
        mem_timeout_err = err_flag;
      end
      default: ;
    endcase
  end

endmodule
